// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with a per-owner burst limit and registered one-hot grant.
// Optional owner lock override is compiled in with `define RR_ARB_LOCK_EN.
module rr_burst_arbiter #(
  parameter int CHANNELS  = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        reset,
`ifdef RR_ARB_LOCK_EN
  input  logic                        lock,
`endif
  input  logic [CHANNELS-1:0]         request,
  output logic [CHANNELS-1:0]         grant,
  output logic [$clog2(CHANNELS)-1:0] grant_id,
  output logic                        grant_valid,
  output logic [CHANNELS-1:0]         nextGrant
);

  localparam int IDW = $clog2(CHANNELS);
  localparam int CW  = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]       MAX_CNT = CW'(MAX_BURST);
  localparam logic [CW-1:0]       ONE_CNT = CW'(1);
  localparam logic [CHANNELS-1:0] PTR_RST = {1'b1, {(CHANNELS-1){1'b0}}};

  typedef enum logic {IDLE, BUSY} state_e;

  state_e              state_q;
  logic [CHANNELS-1:0] ptr_q;
  logic [CHANNELS-1:0] grant_q;
  logic [IDW-1:0]      grant_id_q;
  logic                grant_valid_q;
  logic [CW-1:0]       count_q;
  logic [CW-1:0]       count_d;

  logic [CHANNELS-1:0] above;
  logic [CHANNELS-1:0] next_grant;
  logic [CHANNELS-1:0] winner;
  logic [IDW-1:0]      winner_id;
  logic                hold_lock;
  logic                owner_req;
  logic                burst_done;
  logic                keep_owner;

`ifdef RR_ARB_LOCK_EN
  assign hold_lock = lock;
`else
  assign hold_lock = 1'b0;
`endif

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    // ptr_q is one-hot: ptr | (ptr - 1) covers the pointer and everything below it.
    above      = request & ~(ptr_q | (ptr_q - CHANNELS'(1)));
    next_grant = (|above) ? above : request;
    winner     = next_grant & (~next_grant + CHANNELS'(1));
    winner_id  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (winner[i]) winner_id = IDW'(i);
    end
  end

  assign owner_req  = |(request & grant_q);
  assign burst_done = (count_q == MAX_CNT) && !hold_lock;
  assign keep_owner = owner_req && !burst_done;
  // Under lock the count saturates rather than wrapping past the limit.
  assign count_d    = (count_q == MAX_CNT) ? MAX_CNT : count_q + ONE_CNT;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      ptr_q         <= PTR_RST;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      count_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|request) begin
            state_q       <= BUSY;
            ptr_q         <= winner;
            grant_q       <= winner;
            grant_id_q    <= winner_id;
            grant_valid_q <= 1'b1;
            count_q       <= ONE_CNT;
          end
        end
        BUSY: begin
          if (keep_owner) begin
            count_q <= count_d;
          end else if (|request) begin
            // ptr_q already holds the owner, so the winner is the next requester after it.
            ptr_q         <= winner;
            grant_q       <= winner;
            grant_id_q    <= winner_id;
            grant_valid_q <= 1'b1;
            count_q       <= ONE_CNT;
          end else begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            count_q       <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;
  assign nextGrant   = next_grant;

  a_grant_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(grant_q));
  a_valid_match:  assert property (@(posedge clk) disable iff (!reset) grant_valid_q == (|grant_q));
  a_count_limit:  assert property (@(posedge clk) disable iff (!reset) count_q <= MAX_CNT);
  a_ptr_onehot:   assert property (@(posedge clk) disable iff (!reset) $onehot(ptr_q));

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Scoreboard bench for rr_burst_arbiter: a round-robin reference model predicts each
// cycle, a separate monitor compares nextGrant before the edge and the grant outputs after it.
module tb_rr_burst_arbiter;

  localparam int C   = 8;
  localparam int MB  = 4;
  localparam int IDW = $clog2(C);

  logic           clk;
  logic           reset;
  logic           lock_s;
  logic [C-1:0]   request;
  logic [C-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           grant_valid;
  logic [C-1:0]   nextGrant;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [C-1:0]   nxt;
    logic [C-1:0]   gnt;
    logic [IDW-1:0] id;
    logic           vld;
  } item_t;

  item_t sb_q[$];

  // Reference state: owner index (-1 when idle), last/current owner index, burst count.
  int m_owner;
  int m_ptr;
  int m_cnt;

  rr_burst_arbiter #(.CHANNELS(C), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef RR_ARB_LOCK_EN
    .lock       (lock_s),
`endif
    .request    (request),
    .grant      (grant),
    .grant_id   (grant_id),
    .grant_valid(grant_valid),
    .nextGrant  (nextGrant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [C-1:0] mdl_mask(input logic [C-1:0] r, input int p);
    logic [C-1:0] m;
    m = '0;
    for (int j = p + 1; j < C; j++) m[j] = r[j];
    if (m == '0) m = r;
    return m;
  endfunction

  // Walk the ring starting just after the pointer; the pointer itself is visited last.
  function automatic int mdl_pick(input logic [C-1:0] r, input int p);
    for (int k = 1; k <= C; k++) begin
      if (r[(p + k) % C]) return (p + k) % C;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = C - 1;
    m_cnt   = 0;
  endtask

  task automatic model_step(input logic [C-1:0] r, input logic lk);
    int w;
    if (m_owner < 0) begin
      if (r != '0) begin
        w = mdl_pick(r, m_ptr);
        m_owner = w; m_ptr = w; m_cnt = 1;
      end
    end else if (r[m_owner] && (m_cnt < MB || lk)) begin
      m_cnt = (m_cnt < MB) ? m_cnt + 1 : MB;
    end else if (r != '0) begin
      w = mdl_pick(r, m_ptr);
      m_owner = w; m_ptr = w; m_cnt = 1;
    end else begin
      m_owner = -1; m_cnt = 0;
    end
  endtask

  task automatic drive(input logic [C-1:0] r, input logic lk);
    item_t it;
    @(negedge clk);
    request = r;
    lock_s  = lk;
    it.nxt  = mdl_mask(r, m_ptr);
    model_step(r, lk);
    it.gnt = '0;
    it.id  = '0;
    it.vld = 1'b0;
    if (m_owner >= 0) begin
      it.gnt[m_owner] = 1'b1;
      it.id  = IDW'(m_owner);
      it.vld = 1'b1;
    end
    sb_q.push_back(it);
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #3 reset = 1'b0;
    #1;
    check({tag, "_grant"}, 32'(grant), 32'h0);
    check({tag, "_valid"}, 32'(grant_valid), 32'h0);
    check({tag, "_id"}, 32'(grant_id), 32'h0);
    request = '0;
    lock_s  = 1'b0;
    model_reset();
    @(negedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin : monitor
    item_t mon_it;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        mon_it = sb_q.pop_front();
        check("nextGrant", 32'(nextGrant), 32'(mon_it.nxt));
        @(posedge clk);
        #1;
        check("grant", 32'(grant), 32'(mon_it.gnt));
        check("grant_id", 32'(grant_id), 32'(mon_it.id));
        check("grant_valid", 32'(grant_valid), 32'(mon_it.vld));
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [C-1:0] r;
    logic         lk;
    int           waited;

    reset   = 1'b0;
    request = '0;
    lock_s  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_id", 32'(grant_id), 32'h0);
    check("rst_valid", 32'(grant_valid), 32'h0);
    request = 8'hFF;
    #1;
    check("rst_next_ptr7", 32'(nextGrant), 32'hFF);
    request = '0;
    @(negedge clk);
    #1 reset = 1'b1;

    // Full request: 4-cycle bursts rotating 0..7 and wrapping back to 0.
    repeat (38) drive(8'hFF, 1'b0);
    async_reset("midburst");
    repeat (2) drive(8'hFF, 1'b0);

    // Lone requester keeps the grant across burst boundaries.
    repeat (10) drive(8'h02, 1'b0);

    // Idle with ptr on channel 1, then full request.
    repeat (2) drive(8'h00, 1'b0);
    repeat (3) drive(8'hFF, 1'b0);

    // Owner 0 drops after 2 grant cycles while channel 4 waits.
    drive(8'h00, 1'b0);
    drive(8'h01, 1'b0);
    drive(8'h11, 1'b0);
    repeat (3) drive(8'h10, 1'b0);

`ifdef RR_ARB_LOCK_EN
    async_reset("lock");
    repeat (10) drive(8'hFF, 1'b1);
    repeat (3) drive(8'hFF, 1'b0);
`endif

    r = '0;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0: r = '0;
        1: begin r = '0; r[$urandom_range(0, C - 1)] = 1'b1; end
        2: r = C'($urandom);
        3: r = C'($urandom) | C'($urandom);
        default: ;
      endcase
      lk = 1'b0;
`ifdef RR_ARB_LOCK_EN
      lk = ($urandom_range(0, 7) == 0);
`endif
      drive(r, lk);
      if (n == 200) async_reset("rand");
    end

    waited = 0;
    while (sb_q.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    repeat (2) @(posedge clk);
    check("drain", 32'(sb_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_burst_arbiter.md
RR_BURST_ARBITER -- requirements
Module: rr_burst_arbiter

Interface
REQ-001: Parameter CHANNELS, default 8: number of requesters, legal 2..32.
REQ-002: Parameter MAX_BURST, default 4: maximum consecutive grant cycles per owner, legal 1..255.
REQ-003: clk  input  1  single clock, all state updates on rising edge.
REQ-004: reset  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
REQ-005: request  input  CHANNELS  per-channel request level, bit i = channel i.
REQ-006: lock  input  1  owner burst-limit override; present only with RR_ARB_LOCK_EN.
REQ-007: grant  output  CHANNELS  registered one-hot grant, all-zero when idle.
REQ-008: grant_id  output  $clog2(CHANNELS)  registered binary index of the granted channel, 0 when idle.
REQ-009: grant_valid  output  1  registered, equals OR of grant.
REQ-010: nextGrant  output  CHANNELS  combinational precalculated candidate mask.

Function
REQ-011: Block SHALL hold a one-hot pointer ptr: the current owner while busy, the last owner while idle.
REQ-012: nextGrant SHALL equal request bits strictly above the ptr position; if that set is empty, nextGrant SHALL equal request (wrap-around); if request is 0, nextGrant SHALL be 0.
REQ-013: Winner SHALL be the lowest set bit of nextGrant.
REQ-014: FSM SHALL have two states, IDLE and BUSY.
REQ-015: In IDLE, when request is nonzero at a clock edge, the block SHALL register the winner on grant, load burst count to 1, and go to BUSY (one-cycle latency).
REQ-016: In IDLE with request zero, grant SHALL stay zero.
REQ-017: In BUSY, when the owner's request bit is 1 and count < MAX_BURST, grant SHALL hold and count SHALL increment.
REQ-018: In BUSY, when the owner's request drops or count = MAX_BURST, the block SHALL at the same edge set ptr to the owner and register the new winner with count = 1, with no idle bubble.
REQ-019: If the owner is the only requester at re-arbitration, the owner SHALL be re-granted with count reset to 1.
REQ-020: If request is zero at re-arbitration, grant SHALL go to zero and the FSM SHALL return to IDLE, keeping ptr.
REQ-021: Requests from non-owners SHALL be ignored in BUSY until re-arbitration.
REQ-022: Count width SHALL be $clog2(MAX_BURST+1) and SHALL never exceed MAX_BURST.
REQ-023: grant, grant_id and grant_valid SHALL change only at clock edges or on reset.

Reset
REQ-024: On reset low, grant = 0, grant_id = 0, grant_valid = 0, count = 0, FSM = IDLE, and ptr = bit CHANNELS-1, so channel 0 wins first.
REQ-025: Reset asserted mid-burst SHALL clear the outputs immediately, without waiting for a clock edge.

Configuration
REQ-026: Macro RR_ARB_LOCK_EN defined: lock port exists; while lock = 1 and the owner requests, the MAX_BURST limit SHALL be ignored and count SHALL saturate at MAX_BURST; when lock falls with count = MAX_BURST, re-arbitration SHALL occur at the next edge.
REQ-027: Macro RR_ARB_LOCK_EN undefined: no lock port; the burst limit SHALL always apply.

Verification (CHANNELS=8, MAX_BURST=4)
REQ-028: Reset, then request=8'hFF held -> grant 0x01 for 4 cycles, then 0x02 for 4 cycles, and so on to 0x80, then wraps to 0x01; grant_id goes 0..7.
REQ-029: request=8'b0000_0010 only -> grant 0x02 continuously with no zero cycle at burst boundaries; nextGrant=0x02.
REQ-030: Owner 0x01 with request=8'h11, bit 0 dropped after 2 grant cycles -> grant 0x10 at the next edge, count=1.
REQ-031: Idle with ptr=bit 7 and request=8'hFF -> nextGrant=8'hFF; ptr=bit 1 and request=8'hFF -> nextGrant=8'hFC.
REQ-032: Reset low mid-burst -> grant=0 and grant_valid=0 with no clock edge; after release with request=8'hFF -> first grant 0x01.
REQ-033: With RR_ARB_LOCK_EN, lock=1 and request=8'hFF -> grant 0x01 held 10 cycles; lock to 0 -> grant 0x02 at the next edge.
